// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared FSM states, frame header layout and length encoding
package i2c_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WR_CMD,
      WR_DATA,
      RD_LEN,
      RD_CMD,
      DROP
   } state_t;

   localparam int RW_BIT         = 0;
   localparam int ADDR_LSB       = 1;
   localparam int ADDR_WIDTH     = 7;
   localparam int LEN_ZERO_VALUE = 256;

endpackage

// File: rtl/i2c_frame_rd_track.sv
// rtl/i2c_frame_rd_track.sv - read-return pass-through with remaining-byte count and tlast
module i2c_frame_rd_track #(
   parameter int CNT_WIDTH = 9
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic [CNT_WIDTH-1:0] load_cnt,
   input  logic [7:0]           s_axis_rd_tdata,
   input  logic                 s_axis_rd_tvalid,
   output logic                 s_axis_rd_tready,
   output logic [7:0]           m_axis_rd_tdata,
   output logic                 m_axis_rd_tvalid,
   input  logic                 m_axis_rd_tready,
   output logic                 m_axis_rd_tlast,
   output logic                 rd_pending
);

   logic [CNT_WIDTH-1:0] rd_cnt;
   logic                 rd_hs;

   // Bytes only reach the host while a response is owed; strays are swallowed.
   assign m_axis_rd_tdata  = s_axis_rd_tdata;
   assign m_axis_rd_tvalid = s_axis_rd_tvalid && rd_pending;
   assign s_axis_rd_tready = rd_pending ? m_axis_rd_tready : 1'b1;
   assign m_axis_rd_tlast  = rd_pending && (rd_cnt == CNT_WIDTH'(1));
   assign rd_hs            = s_axis_rd_tvalid && m_axis_rd_tready && rd_pending;

   // Load a new response length, then count returned bytes down to zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_cnt     <= '0;
         rd_pending <= 1'b0;
      end else if (load) begin
         rd_cnt     <= load_cnt;
         rd_pending <= 1'b1;
      end else if (rd_hs) begin
         rd_cnt <= rd_cnt - CNT_WIDTH'(1);
         if (rd_cnt == CNT_WIDTH'(1)) begin
            rd_pending <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/i2c_frame_cmd.sv
// rtl/i2c_frame_cmd.sv - host frame to I2C master command/data converter (optional I2C_FRAME_CMD_ERR_CNT_EN adds err_count)
module i2c_frame_cmd
   import i2c_pkg::*;
#(
   parameter int CNT_WIDTH     = 9,
   parameter int ERR_CNT_WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [7:0]               s_axis_tdata,
   input  logic                     s_axis_tvalid,
   output logic                     s_axis_tready,
   input  logic                     s_axis_tlast,
   output logic [6:0]               m_axis_cmd_address,
   output logic                     m_axis_cmd_start,
   output logic                     m_axis_cmd_read,
   output logic                     m_axis_cmd_write_multiple,
   output logic                     m_axis_cmd_stop,
   output logic                     m_axis_cmd_valid,
   input  logic                     m_axis_cmd_ready,
   output logic [7:0]               m_axis_data_tdata,
   output logic                     m_axis_data_tvalid,
   input  logic                     m_axis_data_tready,
   output logic                     m_axis_data_tlast,
   input  logic [7:0]               s_axis_rd_tdata,
   input  logic                     s_axis_rd_tvalid,
   output logic                     s_axis_rd_tready,
   output logic [7:0]               m_axis_rd_tdata,
   output logic                     m_axis_rd_tvalid,
   input  logic                     m_axis_rd_tready,
   output logic                     m_axis_rd_tlast,
   output logic                     busy,
`ifdef I2C_FRAME_CMD_ERR_CNT_EN
   output logic [ERR_CNT_WIDTH-1:0] err_count,
`endif
   output logic                     status_frame_err
);

   if (CNT_WIDTH < 9 || ERR_CNT_WIDTH < 1) begin : g_param_check
      $error("i2c_frame_cmd: CNT_WIDTH must be >= 9 and ERR_CNT_WIDTH >= 1");
   end

   state_t                 state, state_d;
   logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
   logic                   cmd_valid_q, cmd_valid_d;
   logic                   cmd_start_q, cmd_start_d;
   logic                   cmd_read_q, cmd_read_d;
   logic                   cmd_wm_q, cmd_wm_d;
   logic                   cmd_stop_q, cmd_stop_d;
   logic [CNT_WIDTH-1:0]   cmd_cnt, cmd_cnt_d;
   logic [CNT_WIDTH-1:0]   len_value;
   logic                   err_q, err_d;
   logic                   rd_load;
   logic                   rd_pending;
   logic                   cmd_hs;

   assign len_value = (s_axis_tdata == 8'd0) ? CNT_WIDTH'(LEN_ZERO_VALUE)
                                             : CNT_WIDTH'(s_axis_tdata);
   assign cmd_hs    = cmd_valid_q && m_axis_cmd_ready;

   assign m_axis_cmd_address        = addr_q;
   assign m_axis_cmd_valid          = cmd_valid_q;
   assign m_axis_cmd_start          = cmd_start_q;
   assign m_axis_cmd_read           = cmd_read_q;
   assign m_axis_cmd_write_multiple = cmd_wm_q;
   assign m_axis_cmd_stop           = cmd_stop_q;
   assign status_frame_err          = err_q;
   assign busy                      = (state != IDLE) || rd_pending;

   // Next state, host-side handshake, write pass-through and next command fields.
   always_comb begin
      state_d            = state;
      addr_d             = addr_q;
      cmd_valid_d        = cmd_valid_q;
      cmd_start_d        = cmd_start_q;
      cmd_read_d         = cmd_read_q;
      cmd_wm_d           = cmd_wm_q;
      cmd_stop_d         = cmd_stop_q;
      cmd_cnt_d          = cmd_cnt;
      err_d              = 1'b0;
      rd_load            = 1'b0;
      s_axis_tready      = 1'b0;
      m_axis_data_tdata  = s_axis_tdata;
      m_axis_data_tlast  = s_axis_tlast;
      m_axis_data_tvalid = 1'b0;
      case (state)
         IDLE: begin
            s_axis_tready = !rd_pending;
            if (s_axis_tvalid && !rd_pending) begin
               addr_d = s_axis_tdata[ADDR_LSB +: ADDR_WIDTH];
               if (s_axis_tlast) begin
                  err_d = 1'b1;
               end else if (s_axis_tdata[RW_BIT]) begin
                  state_d = RD_LEN;
               end else begin
                  state_d     = WR_CMD;
                  cmd_valid_d = 1'b1;
                  cmd_start_d = 1'b1;
                  cmd_read_d  = 1'b0;
                  cmd_wm_d    = 1'b1;
                  cmd_stop_d  = 1'b1;
               end
            end
         end
         WR_CMD: begin
            if (cmd_hs) begin
               cmd_valid_d = 1'b0;
               state_d     = WR_DATA;
            end
         end
         WR_DATA: begin
            s_axis_tready      = m_axis_data_tready;
            m_axis_data_tvalid = s_axis_tvalid;
            if (s_axis_tvalid && m_axis_data_tready && s_axis_tlast) begin
               state_d = IDLE;
            end
         end
         RD_LEN: begin
            s_axis_tready = 1'b1;
            if (s_axis_tvalid) begin
               cmd_cnt_d = len_value;
               rd_load   = 1'b1;
               if (s_axis_tlast) begin
                  state_d     = RD_CMD;
                  cmd_valid_d = 1'b1;
                  cmd_start_d = 1'b1;
                  cmd_read_d  = 1'b1;
                  cmd_wm_d    = 1'b0;
                  cmd_stop_d  = (len_value == CNT_WIDTH'(1));
               end else begin
                  state_d = DROP;
                  err_d   = 1'b1;
               end
            end
         end
         DROP: begin
            s_axis_tready = 1'b1;
            if (s_axis_tvalid && s_axis_tlast) begin
               if (cmd_cnt != '0) begin
                  state_d     = RD_CMD;
                  cmd_valid_d = 1'b1;
                  cmd_start_d = 1'b1;
                  cmd_read_d  = 1'b1;
                  cmd_wm_d    = 1'b0;
                  cmd_stop_d  = (cmd_cnt == CNT_WIDTH'(1));
               end else begin
                  state_d = IDLE;
               end
            end
         end
         RD_CMD: begin
            if (cmd_hs) begin
               cmd_cnt_d   = cmd_cnt - CNT_WIDTH'(1);
               cmd_start_d = 1'b0;
               cmd_stop_d  = (cmd_cnt == CNT_WIDTH'(2));
               if (cmd_cnt == CNT_WIDTH'(1)) begin
                  cmd_valid_d = 1'b0;
                  cmd_stop_d  = 1'b0;
                  state_d     = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, latched address, registered command fields and error pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         addr_q      <= '0;
         cmd_valid_q <= 1'b0;
         cmd_start_q <= 1'b0;
         cmd_read_q  <= 1'b0;
         cmd_wm_q    <= 1'b0;
         cmd_stop_q  <= 1'b0;
         cmd_cnt     <= '0;
         err_q       <= 1'b0;
      end else begin
         state       <= state_d;
         addr_q      <= addr_d;
         cmd_valid_q <= cmd_valid_d;
         cmd_start_q <= cmd_start_d;
         cmd_read_q  <= cmd_read_d;
         cmd_wm_q    <= cmd_wm_d;
         cmd_stop_q  <= cmd_stop_d;
         cmd_cnt     <= cmd_cnt_d;
         err_q       <= err_d;
      end
   end

`ifdef I2C_FRAME_CMD_ERR_CNT_EN
   // Saturating count of malformed frames.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_count <= '0;
      end else if (err_q && (err_count != '1)) begin
         err_count <= err_count + ERR_CNT_WIDTH'(1);
      end
   end
`endif

   i2c_frame_rd_track #(
      .CNT_WIDTH (CNT_WIDTH)
   ) u_rd_track (
      .clk              (clk),
      .rst              (rst),
      .load             (rd_load),
      .load_cnt         (len_value),
      .s_axis_rd_tdata  (s_axis_rd_tdata),
      .s_axis_rd_tvalid (s_axis_rd_tvalid),
      .s_axis_rd_tready (s_axis_rd_tready),
      .m_axis_rd_tdata  (m_axis_rd_tdata),
      .m_axis_rd_tvalid (m_axis_rd_tvalid),
      .m_axis_rd_tready (m_axis_rd_tready),
      .m_axis_rd_tlast  (m_axis_rd_tlast),
      .rd_pending       (rd_pending)
   );

endmodule

// File: tb/tb_i2c_frame_cmd.sv
// tb/tb_i2c_frame_cmd.sv - directed self-checking bench for i2c_frame_cmd
module tb_i2c_frame_cmd;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] s_axis_tdata = '0;
   logic       s_axis_tvalid = 1'b0;
   logic       s_axis_tready;
   logic       s_axis_tlast = 1'b0;
   logic [6:0] m_axis_cmd_address;
   logic       m_axis_cmd_start;
   logic       m_axis_cmd_read;
   logic       m_axis_cmd_write_multiple;
   logic       m_axis_cmd_stop;
   logic       m_axis_cmd_valid;
   logic       m_axis_cmd_ready = 1'b1;
   logic [7:0] m_axis_data_tdata;
   logic       m_axis_data_tvalid;
   logic       m_axis_data_tready = 1'b1;
   logic       m_axis_data_tlast;
   logic [7:0] s_axis_rd_tdata = '0;
   logic       s_axis_rd_tvalid = 1'b0;
   logic       s_axis_rd_tready;
   logic [7:0] m_axis_rd_tdata;
   logic       m_axis_rd_tvalid;
   logic       m_axis_rd_tready = 1'b1;
   logic       m_axis_rd_tlast;
   logic       busy;
   logic       status_frame_err;
`ifdef I2C_FRAME_CMD_ERR_CNT_EN
   logic [15:0] err_count;
`endif

   i2c_frame_cmd dut (
      .clk                       (clk),
      .rst                       (rst),
      .s_axis_tdata              (s_axis_tdata),
      .s_axis_tvalid             (s_axis_tvalid),
      .s_axis_tready             (s_axis_tready),
      .s_axis_tlast              (s_axis_tlast),
      .m_axis_cmd_address        (m_axis_cmd_address),
      .m_axis_cmd_start          (m_axis_cmd_start),
      .m_axis_cmd_read           (m_axis_cmd_read),
      .m_axis_cmd_write_multiple (m_axis_cmd_write_multiple),
      .m_axis_cmd_stop           (m_axis_cmd_stop),
      .m_axis_cmd_valid          (m_axis_cmd_valid),
      .m_axis_cmd_ready          (m_axis_cmd_ready),
      .m_axis_data_tdata         (m_axis_data_tdata),
      .m_axis_data_tvalid        (m_axis_data_tvalid),
      .m_axis_data_tready        (m_axis_data_tready),
      .m_axis_data_tlast         (m_axis_data_tlast),
      .s_axis_rd_tdata           (s_axis_rd_tdata),
      .s_axis_rd_tvalid          (s_axis_rd_tvalid),
      .s_axis_rd_tready          (s_axis_rd_tready),
      .m_axis_rd_tdata           (m_axis_rd_tdata),
      .m_axis_rd_tvalid          (m_axis_rd_tvalid),
      .m_axis_rd_tready          (m_axis_rd_tready),
      .m_axis_rd_tlast           (m_axis_rd_tlast),
      .busy                      (busy),
`ifdef I2C_FRAME_CMD_ERR_CNT_EN
      .err_count                 (err_count),
`endif
      .status_frame_err          (status_frame_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // cmd entry: {addr[6:0], start, read, write_multiple, stop}
   logic [10:0] cmd_q[$];
   logic [8:0]  data_q[$];
   logic [8:0]  rd_q[$];
   logic [7:0]  ret_q[$];
   logic [7:0]  next_ret = 8'h00;
   int          err_pulses = 0;
   int          err_long = 0;
   logic        err_prev = 1'b0;
   int          rd_mode = 0;   // 0: host always ready, 1: random, 2: stalled

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] d, input logic last);
      int n;
      n = 0;
      s_axis_tdata  = d;
      s_axis_tvalid = 1'b1;
      s_axis_tlast  = last;
      forever begin
         @(negedge clk);
         if (s_axis_tready) break;
         n++;
         if (n > 3000) begin
            check("send_timeout", 32'd0, 32'd1);
            break;
         end
      end
      @(posedge clk);
      #1;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      forever begin
         @(negedge clk);
         if (!busy) break;
         n++;
         if (n > 5000) begin
            check(tag, 32'd0, 32'd1);
            break;
         end
      end
      tick(1);
   endtask

   task automatic clear_logs();
      cmd_q.delete();
      data_q.delete();
      rd_q.delete();
      err_pulses = 0;
      err_long   = 0;
   endtask

   // Handshake monitors, sampled mid-cycle.
   always @(negedge clk) begin
      if (!rst) begin
         if (m_axis_cmd_valid && m_axis_cmd_ready) begin
            cmd_q.push_back({m_axis_cmd_address, m_axis_cmd_start, m_axis_cmd_read,
                             m_axis_cmd_write_multiple, m_axis_cmd_stop});
            if (m_axis_cmd_read) begin
               ret_q.push_back(next_ret);
               next_ret = next_ret + 8'd1;
            end
         end
         if (m_axis_data_tvalid && m_axis_data_tready)
            data_q.push_back({m_axis_data_tlast, m_axis_data_tdata});
         if (m_axis_rd_tvalid && m_axis_rd_tready)
            rd_q.push_back({m_axis_rd_tlast, m_axis_rd_tdata});
         if (status_frame_err) begin
            err_pulses++;
            if (err_prev) err_long++;
         end
         err_prev = status_frame_err;
      end
   end

   // I2C master read-data responder and host read-ready driver.
   initial begin
      bit hs;
      forever begin
         @(negedge clk);
         hs = s_axis_rd_tvalid && s_axis_rd_tready;
         @(posedge clk);
         #1;
         if (hs) s_axis_rd_tvalid = 1'b0;
         if (!s_axis_rd_tvalid && ret_q.size() > 0) begin
            s_axis_rd_tdata  = ret_q.pop_front();
            s_axis_rd_tvalid = 1'b1;
         end
         case (rd_mode)
            1:       m_axis_rd_tready = 1'($urandom_range(0, 1));
            2:       m_axis_rd_tready = 1'b0;
            default: m_axis_rd_tready = 1'b1;
         endcase
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int bad;
      int nstart;
      int nstop;
      int nlast;

      // Reset state.
      tick(3);
      @(negedge clk);
      check("reset_outputs", {31'd0, m_axis_cmd_valid | m_axis_data_tvalid | m_axis_rd_tvalid | busy | status_frame_err}, 32'd0);
      tick(1);
      rst = 1'b0;
      @(negedge clk);
      check("reset_idle_ready", {30'd0, s_axis_tready, busy}, 32'b10);
      tick(1);

      // Write frame with a stalled command channel.
      clear_logs();
      m_axis_cmd_ready = 1'b0;
      send_byte(8'hA0, 1'b0);
      s_axis_tdata  = 8'h11;
      s_axis_tvalid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("wr_cmd_stall", {18'd0, m_axis_cmd_valid, m_axis_cmd_address, m_axis_cmd_start,
               m_axis_cmd_read, m_axis_cmd_write_multiple, m_axis_cmd_stop, s_axis_tready, busy},
               {18'd0, 1'b1, 7'h50, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1});
      end
      tick(1);
      m_axis_cmd_ready = 1'b1;
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b1);
      check("wr_busy_after", {31'd0, busy}, 32'd0);
      check("wr_cmd_count", cmd_q.size(), 32'd1);
      if (cmd_q.size() >= 1) check("wr_cmd0", {21'd0, cmd_q[0]}, {21'd0, 7'h50, 4'b1011});
      check("wr_data_count", data_q.size(), 32'd2);
      if (data_q.size() == 2) begin
         check("wr_data0", {23'd0, data_q[0]}, {23'd0, 1'b0, 8'h11});
         check("wr_data1", {23'd0, data_q[1]}, {23'd0, 1'b1, 8'h22});
      end

      // Read of three bytes with random host backpressure.
      clear_logs();
      next_ret = 8'h5A;
      rd_mode  = 1;
      send_byte(8'hA1, 1'b0);
      send_byte(8'h03, 1'b1);
      wait_idle("rd3_timeout");
      rd_mode = 0;
      check("rd3_cmd_count", cmd_q.size(), 32'd3);
      if (cmd_q.size() == 3) begin
         check("rd3_cmd0", {21'd0, cmd_q[0]}, {21'd0, 7'h50, 4'b1100});
         check("rd3_cmd1", {21'd0, cmd_q[1]}, {21'd0, 7'h50, 4'b0100});
         check("rd3_cmd2", {21'd0, cmd_q[2]}, {21'd0, 7'h50, 4'b0101});
      end
      check("rd3_resp_count", rd_q.size(), 32'd3);
      if (rd_q.size() == 3) begin
         check("rd3_resp0", {23'd0, rd_q[0]}, {23'd0, 1'b0, 8'h5A});
         check("rd3_resp1", {23'd0, rd_q[1]}, {23'd0, 1'b0, 8'h5B});
         check("rd3_resp2", {23'd0, rd_q[2]}, {23'd0, 1'b1, 8'h5C});
      end

      // Length byte 0 means 256 reads.
      clear_logs();
      next_ret = 8'h00;
      send_byte(8'hA1, 1'b0);
      send_byte(8'h00, 1'b1);
      wait_idle("rd256_timeout");
      check("rd256_cmd_count", cmd_q.size(), 32'd256);
      check("rd256_resp_count", rd_q.size(), 32'd256);
      bad = 0; nstart = 0; nstop = 0; nlast = 0;
      foreach (cmd_q[i]) begin
         if (cmd_q[i][3]) nstart++;
         if (cmd_q[i][0]) nstop++;
      end
      foreach (rd_q[i]) begin
         if (rd_q[i][7:0] != 8'(i)) bad++;
         if (rd_q[i][8]) nlast++;
      end
      check("rd256_starts", nstart, 32'd1);
      check("rd256_stops", nstop, 32'd1);
      check("rd256_seq_errors", bad, 32'd0);
      check("rd256_tlasts", nlast, 32'd1);
      if (cmd_q.size() == 256) begin
         check("rd256_first_cmd", {21'd0, cmd_q[0]}, {21'd0, 7'h50, 4'b1100});
         check("rd256_last_cmd", {21'd0, cmd_q[255]}, {21'd0, 7'h50, 4'b0101});
      end
      if (rd_q.size() == 256) check("rd256_last_resp", {23'd0, rd_q[255]}, {23'd0, 1'b1, 8'hFF});

      // Header-only frame.
      clear_logs();
      send_byte(8'hA0, 1'b1);
      tick(4);
      check("hdr_err_pulses", err_pulses, 32'd1);
      check("hdr_err_width", err_long, 32'd0);
      check("hdr_no_cmd", cmd_q.size(), 32'd0);
      check("hdr_idle", {30'd0, busy, s_axis_tready}, 32'b01);

      // Read frame with a trailing byte that is dropped.
      clear_logs();
      next_ret = 8'h30;
      send_byte(8'hA1, 1'b0);
      send_byte(8'h02, 1'b0);
      send_byte(8'hFF, 1'b1);
      wait_idle("drop_timeout");
      check("drop_err_pulses", err_pulses, 32'd1);
      check("drop_no_data", data_q.size(), 32'd0);
      check("drop_cmd_count", cmd_q.size(), 32'd2);
      if (cmd_q.size() == 2) begin
         check("drop_cmd0", {21'd0, cmd_q[0]}, {21'd0, 7'h50, 4'b1100});
         check("drop_cmd1", {21'd0, cmd_q[1]}, {21'd0, 7'h50, 4'b0101});
      end
      check("drop_resp_count", rd_q.size(), 32'd2);
      if (rd_q.size() == 2) begin
         check("drop_resp0", {23'd0, rd_q[0]}, {23'd0, 1'b0, 8'h30});
         check("drop_resp1", {23'd0, rd_q[1]}, {23'd0, 1'b1, 8'h31});
      end

      // A new header waits for the outstanding read response.
      clear_logs();
      next_ret = 8'hC4;
      rd_mode  = 2;
      send_byte(8'hA1, 1'b0);
      send_byte(8'h01, 1'b1);
      tick(8);
      check("blk_cmd_count", cmd_q.size(), 32'd1);
      s_axis_tdata  = 8'hA0;
      s_axis_tlast  = 1'b1;
      s_axis_tvalid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("blk_header_held", {30'd0, s_axis_tready, busy}, 32'b01);
      end
      tick(1);
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      rd_mode = 0;
      wait_idle("blk_timeout");
      check("blk_no_err", err_pulses, 32'd0);
      check("blk_resp_count", rd_q.size(), 32'd1);
      if (rd_q.size() == 1) check("blk_resp0", {23'd0, rd_q[0]}, {23'd0, 1'b1, 8'hC4});

      // Stray read byte with nothing pending is swallowed.
      clear_logs();
      ret_q.push_back(8'h77);
      tick(5);
      check("stray_not_forwarded", rd_q.size(), 32'd0);
      check("stray_consumed", {31'd0, s_axis_rd_tvalid}, 32'd0);

`ifdef I2C_FRAME_CMD_ERR_CNT_EN
      check("err_count_total", {16'd0, err_count}, 32'd2);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/i2c_frame_cmd.md
Name: i2c_frame_cmd

Overview:
- Downstream neighbour of the AXI-stream byte FIFO. Consumes framed host byte streams (tlast-delimited) and converts each frame into I2C master command and data streams.
- Write frames are forwarded as write-multiple transactions. Read frames generate per-byte read commands.
- Read data returned by the master is re-framed with tlast and sent back to the host.

Parameters:
- CNT_WIDTH, 9, width of read-length counters (must be ≥9 so that length byte 0 encodes 256)
- ERR_CNT_WIDTH, 16, width of optional error counter

Ports:
- clk  in  1  clock
- rst  in  1  reset
- s_axis_tdata  in  8  host frame byte
- s_axis_tvalid  in  1  host byte valid
- s_axis_tready  out  1  host byte ready
- s_axis_tlast  in  1  end of host frame
- m_axis_cmd_address  out  7  I2C 7-bit address
- m_axis_cmd_start  out  1  start/repeated-start request
- m_axis_cmd_read  out  1  read one byte
- m_axis_cmd_write_multiple  out  1  write until data tlast
- m_axis_cmd_stop  out  1  stop after this command
- m_axis_cmd_valid  out  1  command valid
- m_axis_cmd_ready  in  1  command accepted
- m_axis_data_tdata  out  8  write byte to master
- m_axis_data_tvalid  out  1  write byte valid
- m_axis_data_tready  in  1  write byte ready
- m_axis_data_tlast  out  1  last write byte
- s_axis_rd_tdata  in  8  read byte from master
- s_axis_rd_tvalid  in  1  read byte valid
- s_axis_rd_tready  out  1  read byte ready
- m_axis_rd_tdata  out  8  read byte to host
- m_axis_rd_tvalid  out  1  read byte valid
- m_axis_rd_tready  in  1  host ready
- m_axis_rd_tlast  out  1  last byte of read response
- busy  out  1  frame or read response in progress
- status_frame_err  out  1  one-cycle pulse on malformed frame

Behaviour:
- Clock and reset: reset rst, synchronous, active-high; clock clk.
- Reset values: state IDLE; all valid outputs 0; status_frame_err 0; busy 0; all counters 0.
- Frame format:
  - byte0 = {addr[6:0], rw}.
  - rw=0: bytes 1..n are write data.
  - rw=1: byte1 = read length L; L=0 means 256.
- IDLE:
  - s_axis_tready = !rd_pending.
  - On header accept, latch addr and rw.
  - rw=0 and no tlast -> WR_CMD.
  - rw=1 and no tlast -> RD_LEN.
  - Header with tlast -> pulse status_frame_err, stay in IDLE.
- WR_CMD:
  - s_axis_tready=0.
  - Drive cmd_valid=1 with start=1, write_multiple=1, stop=1.
  - On cmd_ready -> WR_DATA.
- WR_DATA:
  - Combinational pass-through: m_axis_data_* = s_axis_*, s_axis_tready = m_axis_data_tready.
  - Accepted byte with tlast -> IDLE.
- RD_LEN:
  - s_axis_tready=1.
  - On accept, load cmd_cnt=L and rd_cnt=L (9-bit); set rd_pending.
  - tlast -> RD_CMD.
  - No tlast -> DROP, pulse status_frame_err; reads are still executed after the drop.
- DROP:
  - s_axis_tready=1; discard bytes until tlast.
  - On tlast -> RD_CMD if a read is latched, else IDLE.
- RD_CMD:
  - cmd_valid=1, cmd_read=1.
  - cmd_start=1 only on the first command.
  - cmd_stop=1 when cmd_cnt==1.
  - Each handshake decrements cmd_cnt; at cmd_cnt==1 with handshake -> IDLE.
- Command outputs are registered. cmd_valid holds, with stable fields, until cmd_ready.
- Read return path (independent of state):
  - Pass-through s_axis_rd -> m_axis_rd.
  - m_axis_rd_tlast = (rd_cnt==1).
  - Each handshake decrements rd_cnt; rd_pending clears on the last handshake.
  - Read bytes arriving when !rd_pending are accepted and discarded.
- busy = (state!=IDLE) || rd_pending.
- Reset mid-frame: immediate return to IDLE. Outstanding master transactions are not tracked.

Optional Feature:
- Macro I2C_FRAME_CMD_ERR_CNT_EN.
- When defined: adds output port err_count [ERR_CNT_WIDTH-1:0]. It increments on each status_frame_err pulse, saturates at all-ones, and resets to 0.
- When undefined: no port and no counter logic; status_frame_err is unchanged.

Decomposition:
- Shared package i2c_pkg:
  - state enum (IDLE, WR_CMD, WR_DATA, RD_LEN, RD_CMD, DROP)
  - frame header bit positions (RW_BIT=0, ADDR_LSB=1)
  - read-length encoding constant (0 -> 256)
- One natural sub-module: i2c_frame_rd_track. It holds rd_cnt, rd_pending, read pass-through and tlast generation.

Test Plan:
- Write frame 0xA0,0x11,0x22(tlast):
  - One command: addr=0x50, start=1, write_multiple=1, stop=1.
  - Data out 0x11, then 0x22 with tlast=1.
  - busy falls after the final byte.
- Read frame 0xA1,0x03(tlast):
  - Three read commands: start=1,0,0 and stop=0,0,1.
  - Master returns 0x5A,0x5B,0x5C -> host receives the same bytes, tlast on 0x5C only.
- Read frame 0xA1,0x00(tlast):
  - 256 read commands issued.
  - m_axis_rd_tlast asserted on the 256th returned byte.
- Header-only frame 0xA0(tlast):
  - status_frame_err pulses exactly one cycle.
  - No command issued; state remains IDLE.
- Read frame 0xA1,0x02,0xFF(tlast):
  - 0xFF is dropped; status_frame_err pulses once.
  - Two read commands still issued.
- Backpressure:
  - Hold cmd_ready=0 for 5 cycles during WR_CMD; command fields stay stable and s_axis_tready=0.
  - Toggle m_axis_rd_tready randomly; no byte is lost or duplicated.
  - New header is blocked (s_axis_tready=0) until the read response completes.
